// File: rtl/cb_dequantizer.sv
// Cb dequantizer: multiplies an 8x8 block of quantized chroma coefficients by the
// JPEG chroma quantization table, one row per cycle, saturating to DATA_W signed.
module cb_dequantizer #(
    parameter int DATA_W = 11,
    parameter int PROD_W = 18
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic [0:7][0:7][DATA_W-1:0]    Q,
    output logic [0:7][0:7][DATA_W-1:0]    Z,
    output logic                           out_enable,
    output logic                           busy,
    output logic                           sat_flag
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                          r_state;
    logic [2:0]                      r_row;
    logic [0:7][0:7][DATA_W-1:0]     r_qbuf;
    logic                            r_sat_acc;

    logic [0:7][DATA_W-1:0]          w_row_q;
    logic [0:7][DATA_W-1:0]          w_row_z;
    logic [7:0][PROD_W-1:0]          w_prod;
    logic [7:0]                      w_row_clip;
    logic                            w_any_clip;

    // Only the upper-left corner of the chroma table differs from 99.
    function automatic logic [6:0] qt_entry(input logic [2:0] r, input logic [2:0] j);
        case ({r, j})
            6'o00: qt_entry = 7'd17;
            6'o01: qt_entry = 7'd18;
            6'o02: qt_entry = 7'd24;
            6'o03: qt_entry = 7'd47;
            6'o10: qt_entry = 7'd18;
            6'o11: qt_entry = 7'd21;
            6'o12: qt_entry = 7'd26;
            6'o13: qt_entry = 7'd66;
            6'o20: qt_entry = 7'd24;
            6'o21: qt_entry = 7'd26;
            6'o22: qt_entry = 7'd56;
            6'o30: qt_entry = 7'd47;
            6'o31: qt_entry = 7'd66;
            default: qt_entry = 7'd99;
        endcase
    endfunction

    always_comb begin
        w_row_q    = r_qbuf[r_row];
        w_row_z    = '0;
        w_prod     = '0;
        w_row_clip = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            w_prod[j] = PROD_W'($signed(w_row_q[j])) *
                        PROD_W'($signed({1'b0, qt_entry(r_row, 3'(j))}));
            // Result fits DATA_W exactly when all bits above the DATA_W sign bit match it.
            w_row_clip[j] = (w_prod[j][PROD_W-1:DATA_W-1] != '0) &&
                            (w_prod[j][PROD_W-1:DATA_W-1] != '1);
            if (w_row_clip[j])
                w_row_z[j] = w_prod[j][PROD_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                 : {1'b0, {(DATA_W-1){1'b1}}};
            else
                w_row_z[j] = w_prod[j][DATA_W-1:0];
        end
        w_any_clip = |w_row_clip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_row      <= '0;
            r_qbuf     <= '0;
            r_sat_acc  <= 1'b0;
            Z          <= '0;
            out_enable <= 1'b0;
            busy       <= 1'b0;
            sat_flag   <= 1'b0;
        end else begin
            out_enable <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_qbuf    <= Q;
                        r_row     <= '0;
                        r_sat_acc <= 1'b0;
                        sat_flag  <= 1'b0;
                        busy      <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    Z[r_row]  <= w_row_z;
                    r_row     <= r_row + 3'd1;
                    r_sat_acc <= r_sat_acc | w_any_clip;
                    if (r_row == 3'd7) begin
                        out_enable <= 1'b1;
                        sat_flag   <= r_sat_acc | w_any_clip;
                        busy       <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cb_dequantizer.sv
// Directed bench for cb_dequantizer: hand-computed vectors plus a clamp-multiply
// golden model for full-block and random checks.
module tb_cb_dequantizer;

    localparam int DATA_W = 11;
    localparam int PROD_W = 18;

    logic                          clk = 1'b0;
    logic                          rst;
    logic                          enable;
    logic [0:7][0:7][DATA_W-1:0]   Q;
    logic [0:7][0:7][DATA_W-1:0]   Z;
    logic                          out_enable;
    logic                          busy;
    logic                          sat_flag;

    int n_assert = 0;
    int n_fail   = 0;
    int qv [8][8];
    int cnt;
    int busy_cnt;
    int oe_cnt;
    logic zero_ok;

    cb_dequantizer #(.DATA_W(DATA_W), .PROD_W(PROD_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .Q          (Q),
        .Z          (Z),
        .out_enable (out_enable),
        .busy       (busy),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    function automatic int qt_of(input int r, input int j);
        if (r >= 4 || j >= 4) return 99;
        case (r * 4 + j)
            0: return 17;  1: return 18;  2: return 24;  3: return 47;
            4: return 18;  5: return 21;  6: return 26;  7: return 66;
            8: return 24;  9: return 26; 10: return 56; 11: return 99;
            12: return 47; 13: return 66; default: return 99;
        endcase
    endfunction

    function automatic int sat_of(input int p);
        if (p > 1023) return 1023;
        if (p < -1024) return -1024;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_q();
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                Q[r][j] = qv[r][j][DATA_W-1:0];
    endtask

    task automatic set_all(input int v);
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                qv[r][j] = v;
        drive_q();
    endtask

    function automatic int z_at(input int r, input int j);
        logic [DATA_W-1:0] v;
        v = Z[r][j];
        return int'($signed(v));
    endfunction

    task automatic check_block(input string tag);
        int exp_sat;
        exp_sat = 0;
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++) begin
                int p;
                p = qv[r][j] * qt_of(r, j);
                if (sat_of(p) != p) exp_sat = 1;
                check($sformatf("%s Z[%0d][%0d]", tag, r, j), z_at(r, j), sat_of(p));
            end
        check({tag, " sat_flag"}, int'(sat_flag), exp_sat);
    endtask

    // Pulses enable for one edge, then waits (bounded) for out_enable.
    task automatic run_block(input string tag);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        cnt = 0;
        busy_cnt = int'(busy);
        while (!out_enable && cnt < 20) begin
            tick();
            cnt++;
            if (busy) busy_cnt++;
        end
        check({tag, " latency"}, cnt, 8);
        check({tag, " busy cycles"}, busy_cnt, 8);
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        Q = '0;
        tick();
        tick();
        rst = 1'b0;
        zero_ok = (Z == '0);
        check("reset Z", int'(zero_ok), 1);
        check("reset out_enable", int'(out_enable), 0);
        check("reset busy", int'(busy), 0);
        check("reset sat_flag", int'(sat_flag), 0);

        // All ones: output equals the table
        set_all(1);
        run_block("ones");
        check("ones Z00", z_at(0, 0), 17);
        check("ones Z11", z_at(1, 1), 21);
        check("ones Z22", z_at(2, 2), 56);
        check("ones Z77", z_at(7, 7), 99);
        check_block("ones");
        tick();
        check("ones pulse width", int'(out_enable), 0);
        check("ones busy after", int'(busy), 0);

        // Sparse block
        set_all(0);
        qv[0][0] = 60; qv[0][1] = -3; qv[3][1] = 5;
        drive_q();
        run_block("sparse");
        check("sparse Z00", z_at(0, 0), 1020);
        check("sparse Z01", z_at(0, 1), -54);
        check("sparse Z31", z_at(3, 1), 330);
        check_block("sparse");

        // Negative with clipping
        set_all(-12);
        run_block("neg");
        check("neg Z00", z_at(0, 0), -204);
        check("neg Z03", z_at(0, 3), -564);
        check("neg Z77", z_at(7, 7), -1024);
        check("neg sat", int'(sat_flag), 1);
        check_block("neg");
        tick();
        check("neg sat holds", int'(sat_flag), 1);

        set_all(2);
        run_block("twos");
        check("twos Z77", z_at(7, 7), 198);
        check("twos sat", int'(sat_flag), 0);
        check_block("twos");

        // Continuous enable, Q changes mid-block
        set_all(1);
        enable = 1'b1;
        tick();
        cnt = 0;
        repeat (3) begin tick(); cnt++; end
        set_all(3);
        while (!out_enable && cnt < 20) begin tick(); cnt++; end
        check("cont latency", cnt, 8);
        for (int r = 0; r < 8; r++)
            for (int j = 0; j < 8; j++)
                check($sformatf("cont first Z[%0d][%0d]", r, j), z_at(r, j), qt_of(r, j));
        tick();
        cnt = 1;
        check("cont accepted busy", int'(busy), 1);
        while (!out_enable && cnt < 20) begin tick(); cnt++; end
        enable = 1'b0;
        check("cont pulse spacing", cnt, 9);
        check("cont Z00", z_at(0, 0), 51);
        check("cont Z77", z_at(7, 7), 297);
        check_block("cont second");
        tick();
        check("cont idle after", int'(busy), 0);

        // Reset mid-block, after row 4 is written
        set_all(-12);
        enable = 1'b1;
        tick();
        enable = 1'b0;
        repeat (5) tick();
        check("abort busy before rst", int'(busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        zero_ok = (Z == '0);
        check("abort Z zero", int'(zero_ok), 1);
        check("abort busy", int'(busy), 0);
        check("abort sat_flag", int'(sat_flag), 0);
        oe_cnt = 0;
        repeat (12) begin
            tick();
            if (out_enable) oe_cnt++;
        end
        check("abort no out_enable", oe_cnt, 0);
        set_all(2);
        run_block("after abort");
        check("after abort Z77", z_at(7, 7), 198);
        check_block("after abort");

        // rst and enable together: rst wins
        rst = 1'b1;
        enable = 1'b1;
        tick();
        rst = 1'b0;
        enable = 1'b0;
        check("rst+en busy", int'(busy), 0);
        tick();
        check("rst+en still idle", int'(busy), 0);

        // Extremes
        set_all(0);
        qv[0][0] = 1023; qv[0][1] = -1024; qv[7][7] = 1023; qv[4][4] = -1; qv[2][2] = 18;
        drive_q();
        run_block("extreme");
        check("extreme Z00", z_at(0, 0), 1023);
        check("extreme Z01", z_at(0, 1), -1024);
        check("extreme Z44", z_at(4, 4), -99);
        check("extreme Z22", z_at(2, 2), 1008);
        check_block("extreme");

        // Random blocks
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 8; r++)
                for (int j = 0; j < 8; j++)
                    qv[r][j] = int'($urandom_range(0, 2047)) - 1024;
            if (b == 3)
                for (int r = 0; r < 8; r++)
                    for (int j = 0; j < 8; j++)
                        qv[r][j] = int'($urandom_range(0, 20)) - 10;
            drive_q();
            run_block($sformatf("rand%0d", b));
            check_block($sformatf("rand%0d", b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
